// File: rtl/io_channel_bank.sv
// Bank of NCH single-register IO channels with core read/write access,
// per-channel external handshakes, a STATUS/IE register and a masked interrupt.
module io_channel_bank #(
  parameter int unsigned      NCH      = 8,
  parameter int unsigned      WIDTH    = 15,
  parameter logic [NCH-1:0]   OUT_MASK = 8'hF0,
  localparam int unsigned     SEL_W    = $clog2(NCH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic [SEL_W-1:0]     IO_read_sel,
  output logic [WIDTH-1:0]     IO_read_data,
  input  logic                 IO_write_en,
  input  logic [SEL_W-1:0]     IO_write_sel,
  input  logic [WIDTH-1:0]     IO_write_data,
  input  logic [NCH-1:0]       ext_in_valid,
  input  logic [NCH*WIDTH-1:0] ext_in_data,
  output logic [NCH-1:0]       ext_out_valid,
  input  logic [NCH-1:0]       ext_out_ready,
  output logic [NCH*WIDTH-1:0] ext_out_data,
  output logic                 irq
);

  logic [NCH-1:0][WIDTH-1:0] chan_q, chan_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            new_q,  new_d;
  logic [NCH-1:0]            ie_q,   ie_d;
  logic [WIDTH-1:0]          rdata_q, rdata_d;

  always_comb begin
    chan_d  = chan_q;
    pend_d  = pend_q;
    new_d   = new_q;
    ie_d    = ie_q;
    rdata_d = rdata_q;

    // Read side effects are evaluated before channel loads so that an
    // external load in the same cycle re-sets the new flag it would clear.
    if (!stall) begin
      rdata_d = '0;
      if (IO_read_sel == SEL_W'(NCH)) begin
        rdata_d[NCH-1:0] = new_q;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (IO_read_sel == SEL_W'(i)) begin
          rdata_d = chan_q[i];
          if (!OUT_MASK[i]) begin
            new_d[i] = 1'b0;
          end
        end
      end
    end

    for (int unsigned i = 0; i < NCH; i++) begin
      if (OUT_MASK[i]) begin
        if (ext_out_ready[i]) begin
          pend_d[i] = 1'b0;
        end
        if (IO_write_en && (IO_write_sel == SEL_W'(i))) begin
          chan_d[i] = IO_write_data;
          pend_d[i] = 1'b1;
        end
      end else if (ext_in_valid[i]) begin
        chan_d[i] = ext_in_data[i*WIDTH +: WIDTH];
        new_d[i]  = 1'b1;
      end
    end

    if (IO_write_en && (IO_write_sel == SEL_W'(NCH))) begin
      ie_d = IO_write_data[NCH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chan_q  <= '0;
      pend_q  <= '0;
      new_q   <= '0;
      ie_q    <= '0;
      rdata_q <= '0;
    end else begin
      chan_q  <= chan_d;
      pend_q  <= pend_d;
      new_q   <= new_d;
      ie_q    <= ie_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ext_out_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (OUT_MASK[i]) begin
        ext_out_data[i*WIDTH +: WIDTH] = chan_q[i];
      end
    end
  end

  assign ext_out_valid = pend_q;
  assign IO_read_data  = rdata_q;
  assign irq           = |(new_q & ie_q & ~OUT_MASK);

endmodule

// File: tb/tb_io_channel_bank.sv
// Self-checking bench for io_channel_bank: default configuration with a read
// scoreboard, plus a directed pass over an NCH=4 / WIDTH=8 instance.
module tb_io_channel_bank;

  localparam logic [3:0] PARK  = 4'hF;
  localparam logic [2:0] BPARK = 3'h7;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [3:0]    rsel;
  logic [14:0]   rdata;
  logic          wen;
  logic [3:0]    wsel;
  logic [14:0]   wdata;
  logic [7:0]    in_valid;
  logic [119:0]  in_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [119:0]  out_data;
  logic          irq;

  logic          b_rst_n;
  logic          b_stall;
  logic [2:0]    b_rsel;
  logic [7:0]    b_rdata;
  logic          b_wen;
  logic [2:0]    b_wsel;
  logic [7:0]    b_wdata;
  logic [3:0]    b_in_valid;
  logic [31:0]   b_in_data;
  logic [3:0]    b_out_valid;
  logic [3:0]    b_out_ready;
  logic [31:0]   b_out_data;
  logic          b_irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        rd_issue;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;
  exp_t exp_q[$];

  io_channel_bank #(.NCH(8), .WIDTH(15), .OUT_MASK(8'hF0)) dut (
    .clock(clk), .reset_n(rst_n), .stall(stall),
    .IO_read_sel(rsel), .IO_read_data(rdata),
    .IO_write_en(wen), .IO_write_sel(wsel), .IO_write_data(wdata),
    .ext_in_valid(in_valid), .ext_in_data(in_data),
    .ext_out_valid(out_valid), .ext_out_ready(out_ready),
    .ext_out_data(out_data), .irq(irq)
  );

  io_channel_bank #(.NCH(4), .WIDTH(8), .OUT_MASK(4'hC)) dut_b (
    .clock(clk), .reset_n(b_rst_n), .stall(b_stall),
    .IO_read_sel(b_rsel), .IO_read_data(b_rdata),
    .IO_write_en(b_wen), .IO_write_sel(b_wsel), .IO_write_data(b_wdata),
    .ext_in_valid(b_in_valid), .ext_in_data(b_in_data),
    .ext_out_valid(b_out_valid), .ext_out_ready(b_out_ready),
    .ext_out_data(b_out_data), .irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] slice(input int unsigned ch);
    return out_data[ch*15 +: 15];
  endfunction

  task automatic wr(input logic [3:0] sel, input logic [14:0] data);
    wen = 1'b1; wsel = sel; wdata = data;
    step();
    wen = 1'b0; wsel = '0;
  endtask

  task automatic rd(input string tag, input logic [3:0] sel, input logic [14:0] exp);
    rsel = sel; rd_issue = 1'b1;
    exp_q.push_back('{tag, exp});
    step();
    rd_issue = 1'b0; rsel = PARK;
  endtask

  task automatic load(input int unsigned ch, input logic [14:0] data);
    in_valid[ch] = 1'b1; in_data[ch*15 +: 15] = data;
    step();
    in_valid = '0;
  endtask

  // Scoreboard: a read issued at one edge is compared just after that edge.
  always @(posedge clk) begin
    if (rst_n && !stall && rd_issue) begin
      exp_t e;
      #1;
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, 32'(rdata), 32'(e.val));
      end
    end
  end

  initial begin
    logic [3:0] stall_sel [3];
    stall_sel = '{4'd3, 4'd8, 4'd2};

    rst_n = 1'b1; stall = 1'b0; rsel = PARK; wen = 1'b0; wsel = '0; wdata = '0;
    in_valid = '0; in_data = '0; out_ready = '0; rd_issue = 1'b0;
    b_rst_n = 1'b1; b_stall = 1'b0; b_rsel = BPARK; b_wen = 1'b0; b_wsel = '0;
    b_wdata = '0; b_in_valid = '0; b_in_data = '0; b_out_ready = '0;
    #2;
    rst_n = 1'b0; b_rst_n = 1'b0;
    #1;
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_b_valid", 32'(b_out_valid), 0);
    step(); step();
    @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;
    step();

    // Output channel write and consume
    wr(4'd5, 15'h1234);
    chk("wr5_valid", 32'(out_valid), 32'h20);
    chk("wr5_data", 32'(slice(5)), 32'h1234);
    out_ready = 8'h20;
    step();
    out_ready = '0;
    chk("rdy5_valid", 32'(out_valid), 0);

    // Input channel load, interrupt, read clears new
    wr(4'd8, 15'h0004);
    load(2, 15'h0ABC);
    chk("ld2_irq", 32'(irq), 1);
    rd("rd2", 4'd2, 15'h0ABC);
    chk("rd2_irq", 32'(irq), 0);

    // External load on an output channel is ignored
    load(5, 15'h7777);
    chk("ign_in5_data", 32'(slice(5)), 32'h1234);
    chk("ign_in5_valid", 32'(out_valid), 0);

    // Read and external load collide on channel 2
    in_valid[2] = 1'b1; in_data[2*15 +: 15] = 15'h0001;
    rsel = 4'd2; rd_issue = 1'b1;
    exp_q.push_back('{"rd2_collide", 15'h0ABC});
    step();
    rd_issue = 1'b0; rsel = PARK; in_valid = '0;
    chk("collide_irq", 32'(irq), 1);
    rd("status_a", 4'd8, 15'h0004);
    rd("status_b", 4'd8, 15'h0004);
    rd("rd2_new", 4'd2, 15'h0001);
    rd("status_c", 4'd8, 15'h0000);

    // Stall holds read data and suppresses side effects
    load(3, 15'h0333);
    rd("rd2_prestall", 4'd2, 15'h0001);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rsel = stall_sel[k];
      step();
      chk("stall_hold", 32'(rdata), 32'h0001);
    end
    stall = 1'b0; rsel = PARK;
    rd("status_stall", 4'd8, 15'h0008);
    rd("rd3", 4'd3, 15'h0333);
    rd("status_d", 4'd8, 15'h0000);

    // Write with simultaneous ready keeps pending; input-channel write ignored
    wr(4'd6, 15'h0666);
    chk("wr6_valid", 32'(out_valid), 32'h40);
    wen = 1'b1; wsel = 4'd6; wdata = 15'h0555; out_ready = 8'h40;
    step();
    wen = 1'b0; out_ready = '0;
    chk("wr6rdy_valid", 32'(out_valid), 32'h40);
    chk("wr6rdy_data", 32'(slice(6)), 32'h0555);
    wr(4'd1, 15'h1111);
    rd("rd1_ignored", 4'd1, 15'h0000);

    // Same-cycle write and read return the pre-write value
    wen = 1'b1; wsel = 4'd7; wdata = 15'h0777;
    rsel = 4'd7; rd_issue = 1'b1;
    exp_q.push_back('{"rd7_prewrite", 15'h0000});
    step();
    wen = 1'b0; rd_issue = 1'b0; rsel = PARK;
    rd("rd7", 4'd7, 15'h0777);
    chk("valid_67", 32'(out_valid), 32'hC0);
    rd("rd_oob", 4'd9, 15'h0000);

    // Out-of-range write must not disturb IE
    wr(4'd9, 15'h0000);
    load(2, 15'h0022);
    chk("oob_wr_irq", 32'(irq), 1);

    // Asynchronous reset mid-handshake
    rd("rd6", 4'd6, 15'h0555);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_data", 32'(out_data == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 0);
    rd("post_rst_status", 4'd8, 15'h0000);
    wr(4'd4, 15'h0044);
    chk("post_rst_wr4_valid", 32'(out_valid), 32'h10);
    chk("post_rst_wr4_data", 32'(slice(4)), 32'h0044);
    rd("post_rst_rd2", 4'd2, 15'h0000);
    step();
    chk("sb_drain", 32'(exp_q.size()), 0);

    // NCH=4, WIDTH=8 instance
    b_wen = 1'b1; b_wsel = 3'd3; b_wdata = 8'hA5;
    step();
    b_wen = 1'b0;
    chk("b_wr3_valid", 32'(b_out_valid), 32'h8);
    chk("b_wr3_data", 32'(b_out_data[31:24]), 32'hA5);
    b_wen = 1'b1; b_wsel = 3'd4; b_wdata = 8'h02;
    step();
    b_wen = 1'b0;
    b_in_valid = 4'h2; b_in_data[15:8] = 8'h3C;
    step();
    b_in_valid = '0;
    chk("b_ld1_irq", 32'(b_irq), 1);
    b_rsel = 3'd1;
    step();
    b_rsel = BPARK;
    chk("b_rd1", 32'(b_rdata), 32'h3C);
    chk("b_rd1_irq", 32'(b_irq), 0);
    b_in_valid = 4'h1; b_in_data[7:0] = 8'h55;
    step();
    b_in_valid = '0;
    b_rsel = 3'd4;
    step();
    chk("b_status", 32'(b_rdata), 32'h01);
    chk("b_ld0_irq", 32'(b_irq), 0);
    b_rsel = 3'd5;
    step();
    chk("b_rd_oob", 32'(b_rdata), 0);
    b_out_ready = 4'h8;
    step();
    b_out_ready = '0;
    chk("b_rdy3_valid", 32'(b_out_valid), 0);
    b_wen = 1'b1; b_wsel = 3'd2; b_wdata = 8'h77;
    b_rsel = 3'd2;
    step();
    b_wen = 1'b0;
    chk("b_rd2_prewrite", 32'(b_rdata), 0);
    step();
    b_rsel = BPARK;
    chk("b_rd2", 32'(b_rdata), 32'h77);
    chk("b_wr2_valid", 32'(b_out_valid), 32'h4);
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("b_mid_rst_valid", 32'(b_out_valid), 0);
    chk("b_mid_rst_rdata", 32'(b_rdata), 0);
    @(negedge clk);
    b_rst_n = 1'b1;
    step();
    chk("b_post_rst_valid", 32'(b_out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
